fib_stream_gen: RTL
===================

FIB_STREAM_GEN -- requirements
Module: fib_stream_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width of n, terms and __output_0.
REQ-002 The block SHALL have parameter DIVISOR, default 2, the filter modulus; legal values are 1..2^WIDTH-1.
REQ-003 The block SHALL have parameter MODE, default 2, the filter: 0 = all terms, 1 = term % DIVISOR != 0, 2 = term % DIVISOR == 0.
REQ-004 The block SHALL have port __clock  input  1  the single clock, all state on its rising edge.
REQ-005 The block SHALL have port __reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port n  input  WIDTH  exclusive upper bound on emitted term values, sampled with __start.
REQ-007 The block SHALL have port __start  input  1  request to begin a run, honoured only in IDLE.
REQ-008 The block SHALL have port __ready  input  1  consumer accepts the current beat.
REQ-009 The block SHALL have port __valid  output  1  __output_0 / __done hold a beat.
REQ-010 The block SHALL have port __done  output  1  marks the terminator beat.
REQ-011 The block SHALL have port __output_0  output  WIDTH  emitted term, or 0 on the terminator beat.
REQ-012 The block SHALL have port __overflow  output  1  present only with FIB_OVF_DETECT_EN; set on an overflow-terminated run.

Function
REQ-013 The block SHALL generate a0=0, a1=1, a(k+2)=a(k)+a(k+1), truncated to WIDTH bits.
REQ-014 The block SHALL implement states IDLE, RUN, TERM:
- IDLE->RUN on __start=1; n, a=0, b=1 are latched.
- RUN examines a, advances (a,b)<=(b,a+b), at most one term per cycle.
- RUN->TERM when a >= n.
- TERM->IDLE when the terminator beat is accepted.
REQ-015 In RUN, a term with a < n that passes MODE/DIVISOR SHALL be emitted as a data beat: __valid=1, __done=0, __output_0=a.
REQ-016 A term that fails the filter SHALL be consumed in one cycle with no beat.
REQ-017 In TERM the block SHALL present exactly one terminator beat: __valid=1, __done=1, __output_0=0.
REQ-018 A beat SHALL be accepted on any cycle with __valid=1 and __ready=1.
REQ-019 While __valid=1 and __ready=0, __valid, __done, __output_0 and the internal state SHALL hold stable.
REQ-020 The output register SHALL reload whenever __ready=1 or __valid=0, giving a sustained throughput of one examined term per cycle under constant __ready=1.
REQ-021 The first beat SHALL appear no earlier than 2 cycles after the __start cycle.
REQ-022 __start SHALL be ignored outside IDLE, and a changing n mid-run SHALL have no effect.
REQ-023 n=0 SHALL yield the terminator beat only.
REQ-024 DIVISOR=1 with MODE=1 SHALL yield the terminator beat only after the term scan completes.

Reset
REQ-025 On __reset=0 the block SHALL asynchronously enter IDLE with __valid=0, __done=0, __output_0=0, __overflow=0 and internal terms 0, regardless of an in-flight run or beat.
REQ-026 A beat pending at reset SHALL be discarded, and the first post-reset run SHALL be unaffected by the aborted one.

Configuration
REQ-027 With FIB_OVF_DETECT_EN defined, a carry-out from a+b SHALL force RUN->TERM after the current term is examined, and __overflow SHALL be 1 on the terminator beat and held until the next __start or reset.
REQ-028 Without FIB_OVF_DETECT_EN, the __overflow port and carry logic SHALL be absent; terms wrap modulo 2^WIDTH, and the run ends only on a >= n.

Verification
REQ-029 WIDTH=32, MODE=2, DIVISOR=2, n=100, __ready=1 -> beats 0,2,8,34, then the terminator (__done=1, __output_0=0), then IDLE.
REQ-030 MODE=1, DIVISOR=2, n=100 -> beats 1,1,3,5,13,21,55,89, then the terminator.
REQ-031 n=0 -> a single terminator beat; a __start pulsed during the run -> no second run.
REQ-032 MODE=2, n=100, __ready=0 for 3 cycles while beat 2 is valid -> __output_0=2 and __valid=1 stable, then 8 follows after __ready rises.
REQ-033 WIDTH=8, MODE=0, n=255:
- With FIB_OVF_DETECT_EN -> beats up to 233, then the terminator with __overflow=1.
- Without it -> the beat after 233 is 121 (377 mod 256).
REQ-034 __reset=0 asserted mid-run after beat 8 -> outputs 0 immediately; a new run with n=10 -> beats 0,2,8, then the terminator.

Source files
------------

// File: rtl/fib_stream_gen.sv
// rtl/fib_stream_gen.sv - Filtered Fibonacci term stream generator with ready/valid output
//
// Walks the Fibonacci sequence (truncated to WIDTH bits), emitting every term
// below the latched bound n that passes the MODE/DIVISOR filter, then a single
// terminator beat (__done=1, __output_0=0).
//
// Parameters:
//   WIDTH   - datapath width of n, the terms and __output_0
//   DIVISOR - filter modulus (1..2^WIDTH-1)
//   MODE    - 0: all terms, 1: term % DIVISOR != 0, 2: term % DIVISOR == 0
//
// Ports:
//   __clock    in   clock, rising edge
//   __reset    in   asynchronous active-low reset
//   n          in   exclusive upper bound on emitted terms, sampled with __start
//   __start    in   begin a run (only honoured when idle)
//   __ready    in   consumer accepts the current beat
//   __valid    out  __output_0/__done hold a beat
//   __done     out  terminator beat marker
//   __output_0 out  emitted term, 0 on the terminator beat
//   __overflow out  only with FIB_OVF_DETECT_EN: run ended on a WIDTH-bit carry
//
// Optional feature macro: FIB_OVF_DETECT_EN (carry detection and __overflow port).

module fib_stream_gen #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIVISOR = WIDTH'(2),
    parameter int unsigned      MODE    = 2
) (
    input  logic             __clock,
    input  logic             __reset,
    input  logic [WIDTH-1:0] n,
    input  logic             __start,
    input  logic             __ready,
    output logic             __valid,
    output logic             __done,
    output logic [WIDTH-1:0] __output_0
`ifdef FIB_OVF_DETECT_EN
    ,
    output logic             __overflow
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_TERM = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    logic             can_load;
    logic             pass;
    logic [WIDTH-1:0] rem;

`ifdef FIB_OVF_DETECT_EN
    // carry_q flags that b_q was produced by a wrapping add, so the term after
    // the one currently in a_q would no longer be a true Fibonacci number.
    logic [WIDTH:0]   sum;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    assign sum = {1'b0, a_q} + {1'b0, b_q};
`else
    logic [WIDTH-1:0] sum;
    assign sum = a_q + b_q;
`endif

    // Output register may take a new beat when empty or when its beat is
    // being accepted this cycle; otherwise everything stalls.
    assign can_load = !valid_q || __ready;

    always_comb begin
        rem  = a_q % DIVISOR;
        pass = 1'b1;
        if (MODE == 1) begin
            pass = (rem != '0);
        end else if (MODE == 2) begin
            pass = (rem == '0);
        end
    end

    always_ff @(posedge __clock or negedge __reset) begin
        if (!__reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            n_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef FIB_OVF_DETECT_EN
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            n_q     <= n_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef FIB_OVF_DETECT_EN
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        n_d     = n_q;
        data_d  = data_q;
        valid_d = valid_q;
        done_d  = done_q;
`ifdef FIB_OVF_DETECT_EN
        carry_d = carry_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (__start) begin
                    state_d = S_RUN;
                    n_d     = n;
                    a_d     = '0;
                    b_d     = WIDTH'(1);
`ifdef FIB_OVF_DETECT_EN
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (can_load) begin
                    if (a_q >= n_q) begin
                        // Bound reached: the terminator goes straight into
                        // the output register.
                        state_d = S_TERM;
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        data_d  = '0;
                    end else begin
                        valid_d = pass;
                        done_d  = 1'b0;
                        if (pass) begin
                            data_d = a_q;
                        end
                        a_d = b_q;
                        b_d = sum[WIDTH-1:0];
`ifdef FIB_OVF_DETECT_EN
                        carry_d = sum[WIDTH];
                        if (carry_q) begin
                            state_d = S_TERM;
                        end
`endif
                    end
                end
            end
            S_TERM: begin
                if (valid_q && done_q) begin
                    if (__ready) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b0;
                    end
                end else if (can_load) begin
                    // Reached only after an overflow stop: the last data beat
                    // may still be occupying the output register.
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    data_d  = '0;
`ifdef FIB_OVF_DETECT_EN
                    ovf_d   = carry_q;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign __valid    = valid_q;
    assign __done     = done_q;
    assign __output_0 = data_q;
`ifdef FIB_OVF_DETECT_EN
    assign __overflow = ovf_q;
`endif

endmodule
